ro_meas_sched: RTL and testbench

RO_MEAS_SCHED -- requirements
Module: ro_meas_sched

---
 rtl/ro_sched_pkg.sv | 36 +++
 rtl/ro_win_timer.sv | 35 +++
 rtl/ro_meas_sched.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ro_meas_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ro_sched_pkg.sv
// Shared definitions for the RO measurement scheduler: register map,
// CTRL/STAT bit positions and the sequencer state encoding.
package ro_sched_pkg;

    // Register byte offsets within the peripheral window
    localparam logic [7:0] OFS_CTRL  = 8'h00;
    localparam logic [7:0] OFS_WIN   = 8'h02;
    localparam logic [7:0] OFS_THR   = 8'h04;
    localparam logic [7:0] OFS_RES_S = 8'h06;
    localparam logic [7:0] OFS_RES_L = 8'h08;
    localparam logic [7:0] OFS_STAT  = 8'h0A;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_SEL_S = 2;
    localparam int CTRL_SEL_L = 3;
    localparam int CTRL_IE    = 4;
    localparam int CTRL_ABORT = 5;

    // STAT bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ALARM_S = 2;
    localparam int STAT_ALARM_L = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SNAP0  = 3'd2,
        WINDOW = 3'd3,
        SNAP1  = 3'd4,
        DONE   = 3'd5
    } ro_state_e;

endpackage

// File: rtl/ro_win_timer.sv
// 16-bit loadable down-counter shared by the settle and window phases.
// Load wins over enable; the count holds at zero.
module ro_win_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [15:0] cnt_q, cnt_d;

    // Next count: load has priority, otherwise decrement while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != 16'd0)) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/ro_meas_sched.sv
// Ring-oscillator measurement scheduler: register block plus sequencer that
// enables one RO at a time, snapshots its counter over a window and reports
// the delta, with threshold alarms and a level interrupt.
module ro_meas_sched
    import ro_sched_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR  = 15'h01C0,
    parameter int          DEC_WD     = 4,
    parameter int          SETTLE_CYC = 4
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic [15:0] cnt_short,
    input  logic [15:0] cnt_long,
    output logic        ro_short_en,
    output logic        ro_long_en,
    output logic        irq_ro
);

    localparam logic [15:0] SETTLE_LD = (SETTLE_CYC > 0) ? 16'(SETTLE_CYC - 1) : 16'd0;

    logic       reg_sel, reg_wr, reg_rd;
    logic [7:0] reg_ofs;
    logic       wr_ctrl, wr_win, wr_thr, wr_stat;

    assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_ofs = 8'({per_addr[DEC_WD-2:0], 1'b0});
    assign reg_wr  = reg_sel & (per_we != 2'b00);
    assign reg_rd  = reg_sel & (per_we == 2'b00);
    assign wr_ctrl = reg_wr & (reg_ofs == OFS_CTRL);
    assign wr_win  = reg_wr & (reg_ofs == OFS_WIN);
    assign wr_thr  = reg_wr & (reg_ofs == OFS_THR);
    assign wr_stat = reg_wr & (reg_ofs == OFS_STAT);

    ro_state_e   state_q, state_d;
    logic        cur_long_q, cur_long_d;
    logic        cont_q, cont_d, sel_s_q, sel_s_d, sel_l_q, sel_l_d, ie_q, ie_d;
    logic [15:0] win_q, win_d, thr_q, thr_d;
    logic [15:0] win_l_q, win_l_d, thr_l_q, thr_l_d;
    logic        sel_s_l_q, sel_s_l_d, sel_l_l_q, sel_l_l_d;
    logic [15:0] start_val_q, start_val_d, delta_q, delta_d;
    logic [15:0] res_s_q, res_s_d, res_l_q, res_l_d;
    logic        done_q, done_d, alarm_s_q, alarm_s_d, alarm_l_q, alarm_l_d;
    logic        ro_short_en_q, ro_short_en_d, ro_long_en_q, ro_long_en_d;
    logic        irq_q, irq_d;

    logic        tmr_load, tmr_en, tmr_zero;
    logic [15:0] tmr_val;
    logic        start_req, abort_req, measuring;
    logic        set_done, set_al_s, set_al_l;
    logic [15:0] cnt_cur;

    assign cnt_cur = cur_long_q ? cnt_long : cnt_short;

    ro_win_timer u_timer (
        .clk      (mclk),
        .rst_n    (puc_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    // Register writes, sequencer next state, flag set/clear and output enables
    always_comb begin
        state_d     = state_q;
        cur_long_d  = cur_long_q;
        cont_d      = cont_q;
        sel_s_d     = sel_s_q;
        sel_l_d     = sel_l_q;
        ie_d        = ie_q;
        win_d       = win_q;
        thr_d       = thr_q;
        win_l_d     = win_l_q;
        thr_l_d     = thr_l_q;
        sel_s_l_d   = sel_s_l_q;
        sel_l_l_d   = sel_l_l_q;
        start_val_d = start_val_q;
        delta_d     = delta_q;
        res_s_d     = res_s_q;
        res_l_d     = res_l_q;
        tmr_load    = 1'b0;
        tmr_val     = 16'd0;
        tmr_en      = 1'b0;
        set_done    = 1'b0;
        set_al_s    = 1'b0;
        set_al_l    = 1'b0;

        start_req = wr_ctrl & per_din[CTRL_START] & (per_din[CTRL_SEL_S] | per_din[CTRL_SEL_L]);
        abort_req = wr_ctrl & per_din[CTRL_ABORT];

        if (wr_ctrl) begin
            cont_d  = per_din[CTRL_CONT];
            sel_s_d = per_din[CTRL_SEL_S];
            sel_l_d = per_din[CTRL_SEL_L];
            ie_d    = per_din[CTRL_IE];
        end
        if (wr_win) win_d = per_din;
        if (wr_thr) thr_d = per_din;

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d    = SETTLE;
                    win_l_d    = win_q;
                    thr_l_d    = thr_q;
                    sel_s_l_d  = per_din[CTRL_SEL_S];
                    sel_l_l_d  = per_din[CTRL_SEL_L];
                    cur_long_d = ~per_din[CTRL_SEL_S];
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (tmr_zero) state_d = SNAP0;
                else          tmr_en  = 1'b1;
            end
            SNAP0: begin
                start_val_d = cnt_cur;
                tmr_load    = 1'b1;
                tmr_val     = (win_l_q == 16'd0) ? 16'd0 : win_l_q - 16'd1;
                state_d     = WINDOW;
            end
            WINDOW: begin
                // The last window cycle supplies the end sample
                if (tmr_zero) begin
                    delta_d = cnt_cur - start_val_q;
                    state_d = SNAP1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            SNAP1: begin
                if (cur_long_q) begin
                    res_l_d  = delta_q;
                    set_al_l = (thr_l_q != 16'd0) && (delta_q < thr_l_q);
                end else begin
                    res_s_d  = delta_q;
                    set_al_s = (thr_l_q != 16'd0) && (delta_q < thr_l_q);
                end
                if (!cur_long_q && sel_l_l_q) begin
                    state_d    = SETTLE;
                    cur_long_d = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                set_done = 1'b1;
                if (cont_q && (sel_s_q || sel_l_q)) begin
                    state_d    = SETTLE;
                    win_l_d    = win_q;
                    thr_l_d    = thr_q;
                    sel_s_l_d  = sel_s_q;
                    sel_l_l_d  = sel_l_q;
                    cur_long_d = ~sel_s_q;
                    tmr_load   = 1'b1;
                    tmr_val    = SETTLE_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops the sequence without touching results or flags
        if (abort_req) begin
            state_d  = IDLE;
            res_s_d  = res_s_q;
            res_l_d  = res_l_q;
            set_done = 1'b0;
            set_al_s = 1'b0;
            set_al_l = 1'b0;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
        end

        // Hardware set beats a same-cycle write-one-to-clear
        done_d    = (done_q    & ~(wr_stat & per_din[STAT_DONE]))    | set_done;
        alarm_s_d = (alarm_s_q & ~(wr_stat & per_din[STAT_ALARM_S])) | set_al_s;
        alarm_l_d = (alarm_l_q & ~(wr_stat & per_din[STAT_ALARM_L])) | set_al_l;

        measuring     = (state_d == SETTLE) || (state_d == SNAP0) ||
                        (state_d == WINDOW) || (state_d == SNAP1);
        ro_short_en_d = measuring & ~cur_long_d;
        ro_long_en_d  = measuring &  cur_long_d;
        irq_d         = ie_d & (done_d | alarm_s_d | alarm_l_d);
    end

    // State and register update with synchronous active-low reset
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state_q       <= IDLE;
            cur_long_q    <= 1'b0;
            cont_q        <= 1'b0;
            sel_s_q       <= 1'b0;
            sel_l_q       <= 1'b0;
            ie_q          <= 1'b0;
            win_q         <= 16'd0;
            thr_q         <= 16'd0;
            win_l_q       <= 16'd0;
            thr_l_q       <= 16'd0;
            sel_s_l_q     <= 1'b0;
            sel_l_l_q     <= 1'b0;
            start_val_q   <= 16'd0;
            delta_q       <= 16'd0;
            res_s_q       <= 16'd0;
            res_l_q       <= 16'd0;
            done_q        <= 1'b0;
            alarm_s_q     <= 1'b0;
            alarm_l_q     <= 1'b0;
            ro_short_en_q <= 1'b0;
            ro_long_en_q  <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_long_q    <= cur_long_d;
            cont_q        <= cont_d;
            sel_s_q       <= sel_s_d;
            sel_l_q       <= sel_l_d;
            ie_q          <= ie_d;
            win_q         <= win_d;
            thr_q         <= thr_d;
            win_l_q       <= win_l_d;
            thr_l_q       <= thr_l_d;
            sel_s_l_q     <= sel_s_l_d;
            sel_l_l_q     <= sel_l_l_d;
            start_val_q   <= start_val_d;
            delta_q       <= delta_d;
            res_s_q       <= res_s_d;
            res_l_q       <= res_l_d;
            done_q        <= done_d;
            alarm_s_q     <= alarm_s_d;
            alarm_l_q     <= alarm_l_d;
            ro_short_en_q <= ro_short_en_d;
            ro_long_en_q  <= ro_long_en_d;
            irq_q         <= irq_d;
        end
    end

    // Combinational read mux; zero when not selected
    always_comb begin
        per_dout = 16'd0;
        if (reg_rd) begin
            case (reg_ofs)
                OFS_CTRL:  per_dout = {11'd0, ie_q, sel_l_q, sel_s_q, cont_q, 1'b0};
                OFS_WIN:   per_dout = win_q;
                OFS_THR:   per_dout = thr_q;
                OFS_RES_S: per_dout = res_s_q;
                OFS_RES_L: per_dout = res_l_q;
                OFS_STAT:  per_dout = {12'd0, alarm_l_q, alarm_s_q, done_q, (state_q != IDLE)};
                default:   per_dout = 16'd0;
            endcase
        end
    end

    assign ro_short_en = ro_short_en_q;
    assign ro_long_en  = ro_long_en_q;
    assign irq_ro      = irq_q;

endmodule

// File: tb/tb_ro_meas_sched.sv
// Directed bench for ro_meas_sched: register access, single/dual RO runs,
// counter wrap, continuous mode, abort, reset and W1C corner cases.
module tb_ro_meas_sched;

    localparam logic [13:0] BASE_W = 14'h00E0;
    localparam logic [7:0]  A_CTRL = 8'h00, A_WIN = 8'h02, A_THR = 8'h04;
    localparam logic [7:0]  A_RESS = 8'h06, A_RESL = 8'h08, A_STAT = 8'h0A;

    logic        mclk = 1'b0;
    logic        puc_rst_n;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [15:0] cnt_short, cnt_long;
    logic        ro_short_en, ro_long_en, irq_ro;

    logic [15:0] cyc = 16'd0;
    logic [15:0] s_base = 16'd0, s_step = 16'd0, l_base = 16'd0, l_step = 16'd0;

    int n_chk = 0;
    int n_pass = 0;

    logic        prev_s = 1'b0, prev_l = 1'b0;
    logic [15:0] rise_s = 16'd0, rise_l = 16'd0, len_s = 16'd0, len_l = 16'd0;
    int          long_rises = 0;
    int          both_hi = 0;

    ro_meas_sched dut (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .per_addr    (per_addr),
        .per_din     (per_din),
        .per_en      (per_en),
        .per_we      (per_we),
        .per_dout    (per_dout),
        .cnt_short   (cnt_short),
        .cnt_long    (cnt_long),
        .ro_short_en (ro_short_en),
        .ro_long_en  (ro_long_en),
        .irq_ro      (irq_ro)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 16'd1;

    assign cnt_short = s_base + s_step * cyc;
    assign cnt_long  = l_base + l_step * cyc;

    // Track enable pulse lengths and overlap
    always @(negedge mclk) begin
        if (ro_short_en && !prev_s) rise_s = cyc;
        if (!ro_short_en && prev_s) len_s = cyc - rise_s;
        if (ro_long_en && !prev_l) begin
            rise_l = cyc;
            long_rises = long_rises + 1;
        end
        if (!ro_long_en && prev_l) len_l = cyc - rise_l;
        if (ro_short_en && ro_long_en) both_hi = both_hi + 1;
        prev_s = ro_short_en;
        prev_l = ro_long_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic rd_raw(input logic [13:0] a, output logic [15:0] d);
        @(negedge mclk);
        per_en = 1'b1; per_we = 2'b00; per_addr = a;
        #1 d = per_dout;
        per_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] ofs, output logic [15:0] d);
        rd_raw(BASE_W + 14'(ofs >> 1), d);
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [15:0] v);
        @(negedge mclk);
        per_en = 1'b1; per_we = 2'b11; per_addr = BASE_W + 14'(ofs >> 1); per_din = v;
        @(negedge mclk);
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic chk_rd(input string tag, input logic [7:0] ofs, input logic [15:0] exp);
        logic [15:0] d;
        rd(ofs, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic wait_stat(input string tag, input int bitn, input logic val);
        logic [15:0] s;
        int n;
        n = 0;
        do begin
            rd(A_STAT, s);
            n = n + 1;
        end while ((s[bitn] !== val) && (n < 3000));
        check(tag, 32'(s[bitn]), 32'(val));
    endtask

    initial begin
        logic [15:0] d;
        int n, lr0;
        puc_rst_n = 1'b0; per_en = 1'b0; per_we = 2'b00; per_addr = 14'd0; per_din = 16'd0;
        repeat (3) @(negedge mclk);
        puc_rst_n = 1'b1;

        // Reset state
        check("rst_short_en", 32'(ro_short_en), 0);
        check("rst_long_en", 32'(ro_long_en), 0);
        check("rst_irq", 32'(irq_ro), 0);
        chk_rd("rst_ctrl", A_CTRL, 16'h0000);
        chk_rd("rst_stat", A_STAT, 16'h0000);
        wr(A_WIN, 16'h1234);
        chk_rd("win_rw", A_WIN, 16'h1234);
        rd_raw(14'h0100, d);
        check("unsel_dout", 32'(d), 0);

        // Single short run, +3 per cycle, WIN=100
        s_step = 16'd3;
        wr(A_WIN, 16'd100);
        wr(A_THR, 16'd0);
        wr(A_CTRL, 16'h0005);
        chk_rd("ctrl_start_selfclr", A_CTRL, 16'h0004);
        wait_stat("t1_idle", 0, 1'b0);
        chk_rd("t1_res_s", A_RESS, 16'd300);
        chk_rd("t1_stat", A_STAT, 16'h0002);
        check("t1_en_len", 32'(len_s), 106);
        wr(A_RESS, 16'hFFFF);
        chk_rd("ro_write_ignored", A_RESS, 16'd300);

        // Counter wrap through 16'hFFFF
        wr(A_STAT, 16'h000E);
        s_step = 16'd1;
        s_base = 16'hFFF0 - cyc;
        wr(A_WIN, 16'd32);
        wr(A_CTRL, 16'h0005);
        wait_stat("t2_idle", 0, 1'b0);
        chk_rd("t2_res_s_wrap", A_RESS, 16'd32);

        // Both ROs, threshold alarm on long, interrupt
        wr(A_STAT, 16'h000E);
        s_step = 16'd2; l_step = 16'd0;
        wr(A_WIN, 16'd40);
        wr(A_THR, 16'd50);
        wr(A_CTRL, 16'h001D);
        wait_stat("t3_idle", 0, 1'b0);
        chk_rd("t3_res_s", A_RESS, 16'd80);
        chk_rd("t3_res_l", A_RESL, 16'd0);
        chk_rd("t3_stat", A_STAT, 16'h000A);
        check("t3_irq", 32'(irq_ro), 1);
        check("t3_len_s", 32'(len_s), 46);
        check("t3_len_l", 32'(len_l), 46);
        wr(A_STAT, 16'h000E);
        check("t3_irq_clr", 32'(irq_ro), 0);
        chk_rd("t3_stat_clr", A_STAT, 16'h0000);

        // Continuous mode with WIN rewritten mid-window, then CONT cleared
        s_step = 16'd1;
        wr(A_THR, 16'd0);
        wr(A_WIN, 16'd20);
        wr(A_CTRL, 16'h0007);
        repeat (10) @(negedge mclk);
        wr(A_WIN, 16'd10);
        wait_stat("t4_done1", 1, 1'b1);
        chk_rd("t4_res_old_win", A_RESS, 16'd20);
        wr(A_STAT, 16'h0002);
        wr(A_CTRL, 16'h0004);
        wait_stat("t4_done2", 1, 1'b1);
        chk_rd("t4_res_new_win", A_RESS, 16'd10);
        wait_stat("t4_idle", 0, 1'b0);

        // Abort during WINDOW keeps results and flags
        wr(A_WIN, 16'd200);
        wr(A_CTRL, 16'h0005);
        repeat (20) @(negedge mclk);
        check("t5_running", 32'(ro_short_en), 1);
        wr(A_CTRL, 16'h0024);
        check("t5_abort_en", 32'(ro_short_en), 0);
        chk_rd("t5_abort_stat", A_STAT, 16'h0002);
        chk_rd("t5_abort_res", A_RESS, 16'd10);
        chk_rd("t5_abort_ctrl", A_CTRL, 16'h0004);

        // Reset during WINDOW zeroes everything
        wr(A_CTRL, 16'h0015);
        repeat (20) @(negedge mclk);
        puc_rst_n = 1'b0;
        @(negedge mclk);
        puc_rst_n = 1'b1;
        check("t5_rst_en", 32'(ro_short_en), 0);
        check("t5_rst_irq", 32'(irq_ro), 0);
        chk_rd("t5_rst_stat", A_STAT, 16'h0000);
        chk_rd("t5_rst_res", A_RESS, 16'h0000);
        chk_rd("t5_rst_win", A_WIN, 16'h0000);

        // START without any SEL bit is ignored
        wr(A_CTRL, 16'h0001);
        chk_rd("t6_nosel_stat", A_STAT, 16'h0000);
        check("t6_nosel_en", 32'(ro_short_en | ro_long_en), 0);

        // START while busy is ignored; new SEL only affects the next latch
        lr0 = long_rises;
        wr(A_WIN, 16'd30);
        wr(A_CTRL, 16'h0005);
        repeat (8) @(negedge mclk);
        wr(A_CTRL, 16'h0009);
        wait_stat("t6_busy_idle", 0, 1'b0);
        chk_rd("t6_busy_res_s", A_RESS, 16'd30);
        chk_rd("t6_busy_res_l", A_RESL, 16'd0);
        check("t6_busy_no_long", 32'(long_rises - lr0), 0);

        // W1C of DONE in the very cycle the sequencer sets it
        wr(A_STAT, 16'h000E);
        wr(A_WIN, 16'd5);
        wr(A_CTRL, 16'h0005);
        n = 0;
        while ((ro_short_en !== 1'b0) && (n < 500)) begin
            @(negedge mclk);
            n = n + 1;
        end
        check("t6_race_reach", 32'(n < 500), 1);
        per_en = 1'b1; per_we = 2'b11; per_addr = BASE_W + 14'd5; per_din = 16'h0002;
        @(negedge mclk);
        per_en = 1'b0; per_we = 2'b00;
        chk_rd("t6_race_done", A_STAT, 16'h0002);

        check("one_enable_max", 32'(both_hi), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
